// File: rtl/bus_slave_mem.sv
// Single-port word memory behind an async-style bus handshake: active-low strobes,
// programmable wait states, and one-cycle registered ready with OR-able read data.
module bus_slave_mem #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rw;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rd_data;
    logic                r_rdy_n;
    logic [31:0]         r_mem [0:DEPTH-1];

    logic                w_req;
    logic                w_enter_ack;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic                w_acc_rw;
    logic [31:0]         w_acc_wdata;
    logic                w_unused;

    assign w_req    = !cs_ && !as_;
    assign w_unused = ^addr[29:ADDR_W];

    // With zero wait states ACK is entered straight from IDLE, so the access
    // must use the live bus inputs rather than the not-yet-latched copies.
    assign w_acc_addr  = (r_state == S_IDLE) ? addr[ADDR_W-1:0] : r_addr;
    assign w_acc_rw    = (r_state == S_IDLE) ? rw               : r_rw;
    assign w_acc_wdata = (r_state == S_IDLE) ? wr_data          : r_wdata;

    always_comb begin
        w_next      = r_state;
        w_enter_ack = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYC == 0) begin
                        w_next      = S_ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Abort outranks the final count.
                if (!w_req) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next      = S_ACK;
                    w_enter_ack = 1'b1;
                end
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_rdy_n   <= 1'b1;
            r_rd_data <= 32'h0;
        end else begin
            r_rdy_n   <= ~w_enter_ack;
            r_rd_data <= (w_enter_ack && w_acc_rw) ? r_mem[w_acc_addr] : 32'h0;
            if (r_state == S_IDLE) begin
                r_cnt <= w_req ? CNT_INIT : 4'd0;
                if (w_req) begin
                    r_addr  <= addr[ADDR_W-1:0];
                    r_rw    <= rw;
                    r_wdata <= wr_data;
                end
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Array has no reset; reset only suppresses a commit landing on its edge.
    always_ff @(posedge clk) begin
        if (reset && w_enter_ack && !w_acc_rw)
            r_mem[w_acc_addr] <= w_acc_wdata;
    end

    assign rd_data = r_rd_data;
    assign rdy_    = r_rdy_n;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: three instances (WAIT_CYC 1, 0, 3) driven by scenario
// tasks and checked against a flat array memory model with latency rules.
module tb_bus_slave_mem;

    logic        clk;
    logic        rst_n [3];
    logic        cs_n  [3];
    logic        as_n  [3];
    logic        rw    [3];
    logic [29:0] addr  [3];
    logic [31:0] wd    [3];
    logic [31:0] rd    [3];
    logic        rdy_n [3];

    logic [31:0] mdl   [3][1024];
    bit          known [3][1024];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_slave_mem #(
            .ADDR_W  (10),
            .WAIT_CYC(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk    (clk),
            .reset  (rst_n[g]),
            .cs_    (cs_n[g]),
            .as_    (as_n[g]),
            .rw     (rw[g]),
            .addr   (addr[g]),
            .wr_data(wd[g]),
            .rd_data(rd[g]),
            .rdy_   (rdy_n[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    // One full bus access; ready expected exactly in the cycle after edge E+WAIT_CYC.
    task automatic xfer(input int k, input bit r, input logic [29:0] a,
                        input logic [31:0] d, input string tag);
        int          w;
        logic [9:0]  idx;
        logic [31:0] exp_d;
        bit          chk;
        w     = wc(k);
        idx   = a[9:0];
        chk   = r ? known[k][idx] : 1'b1;
        exp_d = r ? mdl[k][idx] : 32'h0;
        if (!r) begin
            mdl[k][idx]   = d;
            known[k][idx] = 1'b1;
        end
        cs_n[k] = 1'b0; as_n[k] = 1'b0; rw[k] = r; addr[k] = a; wd[k] = d;
        @(posedge clk);
        for (int j = 0; j <= w + 1; j++) begin
            @(negedge clk);
            total++;
            if (rdy_n[k] !== (j == w ? 1'b0 : 1'b1)) begin
                bad++;
                $display("FAIL %s rdy inst=%0d cyc=%0d got=%b exp=%b", tag, k, j, rdy_n[k], j != w);
            end
            if (j != w || chk) begin
                total++;
                if (rd[k] !== ((j == w) ? exp_d : 32'h0)) begin
                    bad++;
                    $display("FAIL %s data inst=%0d cyc=%0d got=%h exp=%h", tag, k, j, rd[k],
                             (j == w) ? exp_d : 32'h0);
                end
            end
        end
        cs_n[k] = 1'b1; as_n[k] = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdy_n[k] !== 1'b1 || rd[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset inst=%0d rdy=%b rd=%h exp rdy=1 rd=0", k, rdy_n[k], rd[k]);
            end
            rst_n[k] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        xfer(0, 1'b0, 30'd5, 32'hDEADBEEF, "basic_wr");
        xfer(0, 1'b1, 30'd5, 32'h0,        "basic_rd");
    endtask

    task automatic test_back_to_back();
        xfer(1, 1'b0, 30'd0, 32'h11, "b2b_wr0");
        xfer(1, 1'b0, 30'd1, 32'h22, "b2b_wr1");
        xfer(1, 1'b1, 30'd0, 32'h0,  "b2b_rd0");
        xfer(1, 1'b1, 30'd1, 32'h0,  "b2b_rd1");
        xfer(0, 1'b0, 30'd9, 32'hCAFE0009, "raw_wr");
        xfer(0, 1'b1, 30'd9, 32'h0,        "raw_rd");
    endtask

    task automatic test_abort();
        xfer(2, 1'b0, 30'd7, 32'h5555, "abort_pre");
        cs_n[2] = 1'b0; as_n[2] = 1'b0; rw[2] = 1'b0; addr[2] = 30'd7; wd[2] = 32'hAAAA;
        @(posedge clk);
        @(negedge clk);
        as_n[2] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            total++;
            if (rdy_n[2] !== 1'b1 || rd[2] !== 32'h0) begin
                bad++;
                $display("FAIL abort cyc=%0d rdy=%b rd=%h exp rdy=1 rd=0", j, rdy_n[2], rd[2]);
            end
        end
        cs_n[2] = 1'b1;
        xfer(2, 1'b1, 30'd7, 32'h0, "abort_rd");
    endtask

    task automatic test_alias();
        xfer(0, 1'b0, 30'h400, 32'h1234, "alias_wr");
        xfer(0, 1'b1, 30'h0,   32'h0,    "alias_rd");
    endtask

    task automatic test_cs_hold();
        for (int k = 0; k < 3; k++) begin
            cs_n[k] = 1'b1; as_n[k] = 1'b0; rw[k] = 1'b0; addr[k] = 30'd2; wd[k] = 32'hFFFF;
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (rdy_n[k] !== 1'b1 || rd[k] !== 32'h0) begin
                    bad++;
                    $display("FAIL cs_hold inst=%0d cyc=%0d rdy=%b rd=%h", k, j, rdy_n[k], rd[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) as_n[k] = 1'b1;
        for (int k = 0; k < 3; k++) xfer(k, 1'b0, 30'd2, 32'h0202_0000 + 32'(k), "cs_hold_wr");
        for (int k = 0; k < 3; k++) xfer(k, 1'b1, 30'd2, 32'h0, "cs_hold_rd");
    endtask

    // k=2 resets mid-WAIT; k=0 resets exactly on the commit edge.
    task automatic test_reset_wait(input int k);
        xfer(k, 1'b0, 30'd3, 32'h3333_0000 + 32'(k), "rstw_pre");
        cs_n[k] = 1'b0; as_n[k] = 1'b0; rw[k] = 1'b0; addr[k] = 30'd3; wd[k] = 32'hBAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        rst_n[k] = 1'b0;
        @(negedge clk);
        total++;
        if (rdy_n[k] !== 1'b1 || rd[k] !== 32'h0) begin
            bad++;
            $display("FAIL reset_wait inst=%0d rdy=%b rd=%h exp rdy=1 rd=0", k, rdy_n[k], rd[k]);
        end
        rst_n[k] = 1'b1; cs_n[k] = 1'b1; as_n[k] = 1'b1;
        @(negedge clk);
        xfer(k, 1'b1, 30'd3, 32'h0, "reset_wait_rd");
    endtask

    task automatic test_random();
        logic [29:0] a;
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 3; k++) begin
                a      = 30'($urandom);
                a[9:0] = 10'($urandom_range(16, 31));
                xfer(k, 1'($urandom_range(0, 1)), a, 32'($urandom), "random");
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; cs_n[k] = 1'b1; as_n[k] = 1'b1;
            rw[k] = 1'b1; addr[k] = 30'd0; wd[k] = 32'h0;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_alias();
        test_cs_hold();
        test_reset_wait(2);
        test_reset_wait(0);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
